up_fetch: RTL
=============

# up_fetch

Instruction fetch stage sitting directly upstream of up_controller. Holds the program counter and fetches words from program memory over a req/ack handshake. Buffers up to two fetched instructions in a prefetch FIFO and presents them to the controller over a valid/ready handshake. Accepts branch/jump redirects from the controller and flushes stale work.

## Interface
- AW, 8, program address width; PC wraps modulo 2^AW
- DW, 16, instruction width
- RESET_PC, 0, PC value loaded on reset
- clk  input  1  system clock, all logic on rising edge
- nRst  input  1  synchronous reset, active-high (1 = reset), sampled on rising edge of clk
- mem_req  output  1  fetch request to program memory, registered
- mem_addr  output  AW  fetch address, registered, stable while mem_req=1
- mem_ack  input  1  memory response; mem_data valid in same cycle
- mem_data  input  DW  fetched word
- instr_valid  output  1  FIFO head valid toward up_controller
- instr  output  DW  instruction at FIFO head
- instr_pc  output  AW  address the head instruction was fetched from
- instr_ready  input  1  up_controller consumes head when instr_valid & instr_ready
- redirect  input  1  one-cycle pulse: discard all fetched/in-flight work, restart at redirect_pc
- redirect_pc  input  AW  new fetch address, sampled when redirect=1

## Operation
- Reset (nRst=1 at edge): PC=RESET_PC, FIFO empty (count=0), state IDLE, mem_req=0, mem_addr=0, instr_valid=0, instr=0, instr_pc=0. Overrides every other input, including mid-transaction ack.
- Storage: 2-entry FIFO of {pc, word}; instr/instr_pc driven from head; instr_valid = (count != 0); head held stable while valid & !ready.
- Space rule: new request issued only if count_next + 1 <= 2 (at most one outstanding request); FIFO can never overflow, no push is ever dropped for lack of space.
- States:
  - IDLE: mem_req=0. If space -> mem_req=1, mem_addr=PC, PC=PC+1, go REQ.
  - REQ: mem_req=1, mem_addr held. On mem_ack: push {mem_addr, mem_data}; if space after push/pop -> stay REQ with mem_addr=PC, PC=PC+1; else mem_req=0, go IDLE.
  - DROP: in-flight request belonging to a flushed stream; mem_req/mem_addr held (a request is never withdrawn before ack). On mem_ack: data discarded, mem_req=1 with mem_addr=PC, PC=PC+1, go REQ.
- Redirect (highest priority after reset): FIFO flushed (count=0, instr_valid=0 next cycle), PC=redirect_pc. If state REQ and no mem_ack this cycle -> DROP. If REQ with mem_ack same cycle -> acked data discarded, then behave as IDLE with new PC. IDLE -> immediate request at redirect_pc (mem_addr=redirect_pc, PC=redirect_pc+1, REQ). Redirect in DROP -> stay DROP, PC updated to latest redirect_pc.
- Pop with redirect in same cycle: pop is honoured (controller issued it), flush still applies.
- Simultaneous push and pop: both applied, count unchanged.
- Arithmetic: PC and mem_addr AW bits, increment wraps 2^AW-1 -> 0 silently.

## Timing
- mem_req first rises at the first edge with nRst=0; mem_addr=RESET_PC in that cycle.
- Fetch latency: word acked in cycle N appears on instr with instr_valid=1 in cycle N+1.
- Zero-wait memory (mem_ack=1 whenever mem_req=1) and instr_ready=1: one instruction per cycle, consecutive addresses, no bubbles.
- Redirect asserted in cycle N: instr_valid=0 in N+1; with zero-wait memory, mem_addr=redirect_pc in N+1, first new instruction valid in N+2.
- mem_ack while mem_req=0 is ignored.

## Test plan
- Reset: hold nRst=1 5 cycles with mem_ack=1 toggling -> all outputs 0, no push; release -> next cycle mem_req=1, mem_addr=0x00.
- Streaming: mem_ack=1 every cycle, mem_data=0x1000+addr, instr_ready=1 -> instr_pc 0,1,2,... each cycle, instr=0x1000,0x1001,..., no gaps.
- Backpressure: instr_ready=0 -> exactly 2 pushes (pc 0,1), mem_req=0 afterward, instr=0x1000 held; raise ready -> pcs 0,1,2 in order, none lost or duplicated.
- Redirect in flight: mem_ack delayed 3 cycles, redirect=1 redirect_pc=0x40 during wait -> stale ack discarded, next mem_addr=0x40, first instr_pc=0x40; also redirect coinciding with mem_ack -> that word never appears.
- Wrap: RESET_PC=0xFE, streaming -> instr_pc 0xFE,0xFF,0x00,0x01.
- Reset mid-operation: FIFO full plus outstanding request, assert nRst one cycle -> next cycle instr_valid=0, mem_req=0; after release fetch restarts at RESET_PC.

Source files
------------

// File: rtl/up_fetch.sv
`default_nettype none
// ============================================================================
// Module   : up_fetch
// Brief    : Program counter, program-memory fetch over req/ack and a 2-entry
//            prefetch FIFO feeding up_controller, with redirect/flush.
// Revision : 1.0  initial release
// ============================================================================
module up_fetch #(
    parameter int              AW       = 8,
    parameter int              DW       = 16,
    parameter logic [AW-1:0]   RESET_PC = '0
) (
    input  logic          clk,
    input  logic          nRst,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_data,
    output logic          instr_valid,
    output logic [DW-1:0] instr,
    output logic [AW-1:0] instr_pc,
    input  logic          instr_ready,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_pc;
    logic          r_mem_req;
    logic [AW-1:0] r_mem_addr;
    logic [1:0]    r_count;
    logic [AW-1:0] r_head_pc;
    logic [DW-1:0] r_head_word;
    logic [AW-1:0] r_tail_pc;
    logic [DW-1:0] r_tail_word;

    logic          w_pop;
    logic          w_ack;
    logic          w_push;
    logic [1:0]    w_count_next;
    logic          w_space;
    logic          w_issue;
    logic [AW-1:0] w_issue_addr;

    always_comb begin
        w_pop        = (r_count != 2'd0) && instr_ready;
        w_ack        = r_mem_req && mem_ack;
        w_push       = (r_state == S_REQ) && w_ack && !redirect;
        w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};
        w_space      = (w_count_next < 2'd2);

        // A redirect restarts immediately unless a request is still waiting
        // for its ack; that one must complete (and be discarded) first.
        w_issue      = 1'b0;
        w_issue_addr = r_pc;
        if (redirect) begin
            w_issue_addr = redirect_pc;
            w_issue      = !(r_mem_req && !mem_ack);
        end else begin
            case (r_state)
                S_IDLE:  w_issue = w_space;
                S_REQ:   w_issue = w_ack && w_space;
                S_DROP:  w_issue = w_ack;
                default: w_issue = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (nRst) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_count     <= 2'd0;
            r_head_pc   <= '0;
            r_head_word <= '0;
            r_tail_pc   <= '0;
            r_tail_word <= '0;
        end else begin
            if (redirect) begin
                r_count <= 2'd0;
            end else begin
                r_count <= w_count_next;
                if (w_pop && (r_count == 2'd2)) begin
                    r_head_pc   <= r_tail_pc;
                    r_head_word <= r_tail_word;
                    if (w_push) begin
                        r_tail_pc   <= r_mem_addr;
                        r_tail_word <= mem_data;
                    end
                end else if (w_push && ((r_count == 2'd0) || w_pop)) begin
                    r_head_pc   <= r_mem_addr;
                    r_head_word <= mem_data;
                end else if (w_push) begin
                    r_tail_pc   <= r_mem_addr;
                    r_tail_word <= mem_data;
                end
            end

            if (w_issue) begin
                r_mem_req  <= 1'b1;
                r_mem_addr <= w_issue_addr;
                r_pc       <= w_issue_addr + AW'(1);
                r_state    <= S_REQ;
            end else if (redirect) begin
                r_pc    <= redirect_pc;
                r_state <= S_DROP;
            end else if (w_ack) begin
                r_mem_req <= 1'b0;
                r_state   <= S_IDLE;
            end
        end
    end

    assign mem_req     = r_mem_req;
    assign mem_addr    = r_mem_addr;
    assign instr_valid = (r_count != 2'd0);
    assign instr       = r_head_word;
    assign instr_pc    = r_head_pc;

endmodule
`default_nettype wire
